instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 87 ++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-queue to decode handshake.
// Source drives the queue head; sink drives ready.
interface instr_fetch_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;

  modport master (
    output out_valid,
    output out_ins,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ins,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC generator and 2-entry registered fetch
// queue feeding decode, with redirect and sticky fetch error.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 48,
  parameter int unsigned DEPTH     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_ins,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          fetch_err,
  instr_fetch_if.master fq
);
  localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic [31:0]   pc;
  logic          err_q;
  logic          pc_bad;
  logic          pop;
  logic          fetch;
  logic          slot0;
  logic [CW-1:0] cnt;
  ent_t          e0;
  ent_t          e1;
  ent_t          ent_new;

  assign pc_bad    = (pc[1:0] != 2'b00) || (pc > LAST);
  assign fetch_err = err_q | pc_bad;
  assign imem_addr = pc;
  assign pop       = fq.out_valid && fq.out_ready;
  assign fetch     = !redirect_valid && !fetch_err
                  && ((cnt < FULL) || pop);
  // new entry goes to the head when the queue is empty after pop
  assign slot0     = (cnt == '0)
                  || ((cnt == CW'(1)) && pop);
  assign ent_new   = {pc, imem_ins};

  assign fq.out_valid = (cnt != '0);
  assign fq.out_ins   = e0.ins;
  assign fq.out_pc    = e0.pc;

  // PC and sticky error: redirect wins, else advance on fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      unique case (1'b1)
        redirect_valid: begin
          pc    <= redirect_pc;
          err_q <= 1'b0;
        end
        fetch: pc <= pc + 32'd4;
        default: err_q <= err_q | pc_bad;
      endcase
    end
  end

  // queue: head in e0; redirect flushes and ignores pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      e0  <= '0;
      e1  <= '0;
    end else if (redirect_valid) begin
      cnt <= '0;
    end else begin
      if (pop)
        e0 <= e1;
      if (fetch && slot0)
        e0 <= ent_new;
      if (fetch && !slot0)
        e1 <= ent_new;
      cnt <= cnt + CW'(fetch) - CW'(pop);
    end
  end
endmodule
